// File: rtl/multi_arbiter_game_if.sv
// Player-side bus of the reaction-game core.
//   start_in         : level request for a new round
//   req_n_in         : active-low player buttons (asynchronous)
//   leds_out         : registered per-player LED drive
//   winner_valid_out : one-cycle pulse when a grant is made
//   winner_id_out    : index of the last granted player
//   foul_out         : high while a false start is being shown
//   scores_out       : packed saturating scores, player i at [i*SCORE_W +: SCORE_W]
interface multi_arbiter_game_if #(
  parameter int NUM_PLAYERS = 4,
  parameter int SCORE_W     = 4
);
  localparam int ID_W = $clog2(NUM_PLAYERS);

  logic                           start_in;
  logic [NUM_PLAYERS-1:0]         req_n_in;
  logic [NUM_PLAYERS-1:0]         leds_out;
  logic                           winner_valid_out;
  logic [ID_W-1:0]                winner_id_out;
  logic                           foul_out;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores_out;

  modport master (
    output start_in, req_n_in,
    input  leds_out, winner_valid_out, winner_id_out, foul_out, scores_out
  );

  modport slave (
    input  start_in, req_n_in,
    output leds_out, winner_valid_out, winner_id_out, foul_out, scores_out
  );
endinterface

// File: rtl/multi_arbiter_game.sv
// N-player reaction-game core: countdown, first-press grant with round-robin
// tie-breaking, false-start detection and per-player saturating scores.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : player-side bus (slave modport), see multi_arbiter_game_if

// Per-player saturating up/down score counter.
module multi_arbiter_game_score #(
  parameter int SCORE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               dec,
  output logic [SCORE_W-1:0] score
);
  always_ff @(posedge clk) begin
    if (reset)                     score <= '0;
    else if (inc && score != '1)   score <= score + 1'b1;
    else if (dec && score != '0)   score <= score - 1'b1;
  end
endmodule

module multi_arbiter_game #(
  parameter int NUM_PLAYERS     = 4,
  parameter int CLOCK_FREQ      = 1000,
  parameter int PRESCALER_COUNT = CLOCK_FREQ/4,
  parameter int CD_TICKS        = 4,
  parameter int SHOW_TICKS      = 8,
  parameter int SCORE_W         = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  multi_arbiter_game_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_PLAYERS);
  localparam int PS_W = $clog2(PRESCALER_COUNT);
  localparam int CD_W = $clog2(CD_TICKS) + 1;
  localparam int SH_W = $clog2(SHOW_TICKS) + 1;

  typedef enum logic [2:0] {IDLE, COUNTDOWN, ARMED, SHOW, FOUL} state_t;

  state_t                                 state;
  logic [1:0][NUM_PLAYERS-1:0]            sync_pipe;
  logic [NUM_PLAYERS-1:0]                 req;
  logic [PS_W-1:0]                        presc;
  logic                                   tick;
  logic [CD_W-1:0]                        cd_cnt;
  logic [SH_W-1:0]                        show_cnt;
  logic [ID_W-1:0]                        rr_ptr, offender, grant_id, low_id, rr_next;
  logic [NUM_PLAYERS-1:0]                 leds;
  logic                                   win_vld, foul;
  logic [ID_W-1:0]                        win_id;
  logic [NUM_PLAYERS-1:0]                 inc_vec, dec_vec;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0]    scores;

  // Stage 1 holds the inverted raw buttons, stage 2 is the decision input.
  assign req  = sync_pipe[1];
  assign tick = (presc == PS_W'(PRESCALER_COUNT-1));

  // First pressed player searching upward from rr_ptr, wrapping.
  always_comb begin : rr_search
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    logic            found;
    sum      = '0;
    idx      = '0;
    found    = 1'b0;
    grant_id = rr_ptr;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_PLAYERS)) sum = sum - (ID_W+1)'(NUM_PLAYERS);
      idx = sum[ID_W-1:0];
      if (!found && req[idx]) begin
        found    = 1'b1;
        grant_id = idx;
      end
    end
  end

  // False starts blame the lowest-index pressed player.
  always_comb begin
    low_id = '0;
    for (int i = NUM_PLAYERS-1; i >= 0; i--)
      if (req[i]) low_id = ID_W'(i);
  end

  assign rr_next = (grant_id == ID_W'(NUM_PLAYERS-1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (state == ARMED     && |req) inc_vec[grant_id] = 1'b1;
    if (state == COUNTDOWN && |req) dec_vec[low_id]   = 1'b1;
  end

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_score
    multi_arbiter_game_score #(.SCORE_W(SCORE_W)) u_score (
      .clk   (clk),
      .reset (reset),
      .inc   (inc_vec[i]),
      .dec   (dec_vec[i]),
      .score (scores[i])
    );
  end

  // LEDs are computed from the current state, so they trail state by a cycle.
  // The prescaler is cleared on every state entry so each phase starts aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sync_pipe <= '0;
      presc     <= '0;
      cd_cnt    <= '0;
      show_cnt  <= '0;
      rr_ptr    <= '0;
      offender  <= '0;
      leds      <= '0;
      win_vld   <= 1'b0;
      win_id    <= '0;
      foul      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], ~bus.req_n_in};
      presc     <= tick ? '0 : presc + 1'b1;
      win_vld   <= 1'b0;
      unique case (state)
        IDLE: begin
          leds <= '0;
          if (bus.start_in && !(|req)) begin
            state  <= COUNTDOWN;
            cd_cnt <= '0;
            presc  <= '0;
          end
        end
        COUNTDOWN: begin
          leds <= cd_cnt[0] ? '0 : '1;
          if (|req) begin
            state    <= FOUL;
            offender <= low_id;
            foul     <= 1'b1;
            show_cnt <= '0;
            presc    <= '0;
          end else if (tick) begin
            cd_cnt <= cd_cnt + 1'b1;
            if (cd_cnt == CD_W'(CD_TICKS-1)) begin
              state <= ARMED;
              presc <= '0;
            end
          end
        end
        ARMED: begin
          leds <= '0;
          if (|req) begin
            win_id   <= grant_id;
            win_vld  <= 1'b1;
            rr_ptr   <= rr_next;
            state    <= SHOW;
            show_cnt <= '0;
            presc    <= '0;
          end
        end
        SHOW: begin
          leds <= NUM_PLAYERS'(1) << win_id;
          if (tick) begin
            show_cnt <= show_cnt + 1'b1;
            if (show_cnt == SH_W'(SHOW_TICKS-1)) begin
              state <= IDLE;
              presc <= '0;
            end
          end
        end
        FOUL: begin
          // Even tick counts light the offender, odd ones blank it.
          leds <= show_cnt[0] ? '0 : NUM_PLAYERS'(1) << offender;
          if (tick) begin
            show_cnt <= show_cnt + 1'b1;
            if (show_cnt == SH_W'(SHOW_TICKS-1)) begin
              state <= IDLE;
              foul  <= 1'b0;
              presc <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.leds_out         = leds;
  assign bus.winner_valid_out = win_vld;
  assign bus.winner_id_out    = win_id;
  assign bus.foul_out         = foul;
  assign bus.scores_out       = scores;
endmodule

// File: tb/tb_multi_arbiter_game.sv
module tb_multi_arbiter_game;
  localparam int NP = 4;
  localparam int SW = 4;
  localparam int PS = 4;
  localparam int SHOW_CYC = 8 * PS;

  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;

  multi_arbiter_game_if #(.NUM_PLAYERS(NP), .SCORE_W(SW)) bus();

  multi_arbiter_game #(
    .NUM_PLAYERS(NP), .CLOCK_FREQ(16), .PRESCALER_COUNT(PS),
    .CD_TICKS(4), .SHOW_TICKS(8), .SCORE_W(SW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Round-level reference model: scores and round-robin pointer.
  int exp_score[NP];
  int exp_rr;

  function automatic void model_reset();
    for (int i = 0; i < NP; i++) exp_score[i] = 0;
    exp_rr = 0;
  endfunction

  function automatic int rr_pick(logic [NP-1:0] m, int rr);
    for (int k = 0; k < NP; k++)
      if (m[(rr + k) % NP]) return (rr + k) % NP;
    return -1;
  endfunction

  function automatic int low_bit(logic [NP-1:0] m);
    for (int i = 0; i < NP; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic void model_win(int g);
    if (exp_score[g] < (1 << SW) - 1) exp_score[g]++;
    exp_rr = (g + 1) % NP;
  endfunction

  function automatic void model_foul(int o);
    if (exp_score[o] > 0) exp_score[o]--;
  endfunction

  function automatic logic [NP*SW-1:0] exp_packed();
    logic [NP*SW-1:0] p;
    p = '0;
    for (int i = 0; i < NP; i++) p[i*SW +: SW] = SW'(exp_score[i]);
    return p;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; bus.start_in = 1'b0; bus.req_n_in = '1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_start();
    @(negedge clk); bus.start_in = 1'b1;
    @(negedge clk); bus.start_in = 1'b0;
  endtask

  // Full round with a press in ARMED; reports pulses, granted id and
  // how many cycles the LEDs showed the granted player's one-hot.
  task automatic run_round(input logic [NP-1:0] mask, output int pulses,
                           output int gid, output int led_hits);
    logic [NP-1:0] oh;
    do_start();
    repeat (20) @(negedge clk);
    bus.req_n_in = ~mask;
    pulses = 0; gid = -1; led_hits = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.winner_valid_out) begin pulses++; gid = int'(bus.winner_id_out); end
      if (c == 4) bus.req_n_in = '1;
      if (gid >= 0) begin
        oh = NP'(1) << gid;
        if (bus.leds_out == oh) led_hits++;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  // Press during countdown; reports foul length, LED blink errors and pulses.
  task automatic run_foul(input logic [NP-1:0] mask, input int delay,
                          output int foul_cyc, output int led_errs, output int pulses);
    logic [NP-1:0] oh, exp_led;
    int k;
    do_start();
    repeat (delay) @(negedge clk);
    bus.req_n_in = ~mask;
    oh = NP'(1) << low_bit(mask);
    foul_cyc = 0; led_errs = 0; pulses = 0; k = -1;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (bus.winner_valid_out) pulses++;
      if (bus.foul_out) begin
        if (k < 0) k = 0;
        foul_cyc++;
      end
      if (c == 4) bus.req_n_in = '1;
      if (k >= 1 && k <= SHOW_CYC) begin
        exp_led = (((k - 1) / PS) % 2 == 0) ? oh : '0;
        if (bus.leds_out !== exp_led) led_errs++;
      end
      if (k >= 0) k++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++; if (bus.leds_out !== '0) $display("FAIL rst_leds got %b exp 0", bus.leds_out); else n_pass++;
    n_total++; if (bus.winner_valid_out !== 1'b0) $display("FAIL rst_valid got %b exp 0", bus.winner_valid_out); else n_pass++;
    n_total++; if (bus.winner_id_out !== '0) $display("FAIL rst_id got %0d exp 0", bus.winner_id_out); else n_pass++;
    n_total++; if (bus.foul_out !== 1'b0) $display("FAIL rst_foul got %b exp 0", bus.foul_out); else n_pass++;
    n_total++; if (bus.scores_out !== '0) $display("FAIL rst_scores got %h exp 0", bus.scores_out); else n_pass++;
  endtask

  task automatic test_single_grant();
    int p, g, h, e;
    run_round(4'b0100, p, g, h);
    e = rr_pick(4'b0100, exp_rr); model_win(e);
    n_total++; if (p !== 1) $display("FAIL single_pulses got %0d exp 1", p); else n_pass++;
    n_total++; if (g !== e) $display("FAIL single_id got %0d exp %0d", g, e); else n_pass++;
    n_total++; if (h !== SHOW_CYC) $display("FAIL single_leds got %0d exp %0d", h, SHOW_CYC); else n_pass++;
    n_total++; if (bus.scores_out !== exp_packed()) $display("FAIL single_score got %h exp %h", bus.scores_out, exp_packed()); else n_pass++;
    // rr_ptr now points at 3, so P3 beats P1
    run_round(4'b1010, p, g, h);
    e = rr_pick(4'b1010, exp_rr); model_win(e);
    n_total++; if (g !== e) $display("FAIL rr_after_p2 got %0d exp %0d", g, e); else n_pass++;
  endtask

  task automatic test_simultaneous();
    int p, g, h, e;
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      run_round(4'b1001, p, g, h);
      e = rr_pick(4'b1001, exp_rr); model_win(e);
      n_total++; if (p !== 1 || g !== e) $display("FAIL simul_r%0d got id %0d pulses %0d exp id %0d pulses 1", r, g, p, e); else n_pass++;
    end
    n_total++; if (bus.scores_out !== exp_packed()) $display("FAIL simul_score got %h exp %h", bus.scores_out, exp_packed()); else n_pass++;
  endtask

  task automatic test_foul();
    int fc, le, p, g, h;
    apply_reset();
    run_foul(4'b0010, 8, fc, le, p);
    model_foul(1);
    n_total++; if (fc !== SHOW_CYC) $display("FAIL foul_len got %0d exp %0d", fc, SHOW_CYC); else n_pass++;
    n_total++; if (le !== 0) $display("FAIL foul_blink got %0d errs exp 0", le); else n_pass++;
    n_total++; if (p !== 0) $display("FAIL foul_pulse got %0d exp 0", p); else n_pass++;
    n_total++; if (bus.scores_out !== exp_packed()) $display("FAIL foul_sat0 got %h exp %h", bus.scores_out, exp_packed()); else n_pass++;
    for (int r = 0; r < 3; r++) begin
      run_round(4'b0010, p, g, h);
      model_win(rr_pick(4'b0010, exp_rr));
    end
    run_foul(4'b0010, 8, fc, le, p);
    model_foul(1);
    n_total++; if (bus.scores_out[1*SW +: SW] !== 4'd2) $display("FAIL foul_dec got %0d exp 2", bus.scores_out[1*SW +: SW]); else n_pass++;
    n_total++; if (bus.scores_out !== exp_packed()) $display("FAIL foul_scores got %h exp %h", bus.scores_out, exp_packed()); else n_pass++;
  endtask

  task automatic test_saturation();
    int p, g, h;
    apply_reset();
    for (int r = 0; r < 16; r++) begin
      run_round(4'b0001, p, g, h);
      model_win(rr_pick(4'b0001, exp_rr));
    end
    n_total++; if (bus.scores_out[SW-1:0] !== 4'd15) $display("FAIL sat_score0 got %0d exp 15", bus.scores_out[SW-1:0]); else n_pass++;
    n_total++; if (bus.scores_out !== exp_packed()) $display("FAIL sat_scores got %h exp %h", bus.scores_out, exp_packed()); else n_pass++;
  endtask

  task automatic test_reset_mid_round();
    int p, g, h, e;
    do_start();
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_total++; if ({bus.leds_out, bus.winner_valid_out, bus.winner_id_out, bus.foul_out} !== '0)
      $display("FAIL midcd_outs got %b exp 0", {bus.leds_out, bus.winner_valid_out, bus.winner_id_out, bus.foul_out}); else n_pass++;
    n_total++; if (bus.scores_out !== '0) $display("FAIL midcd_scores got %h exp 0", bus.scores_out); else n_pass++;
    reset = 1'b0; model_reset();
    repeat (3) @(negedge clk);
    do_start();
    repeat (20) @(negedge clk);
    bus.req_n_in = ~4'b0010;
    repeat (10) @(negedge clk);
    bus.req_n_in = '1;
    reset = 1'b1;
    @(negedge clk);
    n_total++; if ({bus.leds_out, bus.winner_valid_out, bus.winner_id_out, bus.foul_out} !== '0)
      $display("FAIL midshow_outs got %b exp 0", {bus.leds_out, bus.winner_valid_out, bus.winner_id_out, bus.foul_out}); else n_pass++;
    n_total++; if (bus.scores_out !== '0) $display("FAIL midshow_scores got %h exp 0", bus.scores_out); else n_pass++;
    reset = 1'b0; model_reset();
    repeat (4) @(negedge clk);
    run_round(4'b1010, p, g, h);
    e = rr_pick(4'b1010, exp_rr); model_win(e);
    n_total++; if (g !== e) $display("FAIL midshow_rr got %0d exp %0d", g, e); else n_pass++;
  endtask

  task automatic test_start_blocked();
    int lit;
    bit seen;
    bus.req_n_in = ~4'b0100;
    repeat (4) @(negedge clk);
    bus.start_in = 1'b1;
    lit = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.leds_out !== '0) lit++;
    end
    n_total++; if (lit !== 0) $display("FAIL blocked_idle got %0d lit cycles exp 0", lit); else n_pass++;
    bus.req_n_in = '1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.leds_out === '1) seen = 1'b1;
    end
    n_total++; if (seen !== 1'b1) $display("FAIL blocked_release got %b exp 1", seen); else n_pass++;
    bus.start_in = 1'b0;
    apply_reset();
  endtask

  task automatic test_random();
    int p, g, h, e, fc, le, fouls;
    logic [NP-1:0] m;
    fouls = 0;
    for (int r = 0; r < 24; r++) begin
      m = NP'($urandom_range(1, (1 << NP) - 1));
      if ($urandom_range(0, 3) == 0) begin
        run_foul(m, $urandom_range(0, 10), fc, le, p);
        model_foul(low_bit(m));
        fouls++;
        n_total++; if (fc !== SHOW_CYC || p !== 0) $display("FAIL rnd_foul_r%0d got len %0d pulses %0d exp len %0d pulses 0", r, fc, p, SHOW_CYC); else n_pass++;
      end else begin
        run_round(m, p, g, h);
        e = rr_pick(m, exp_rr); model_win(e);
        n_total++; if (p !== 1 || g !== e) $display("FAIL rnd_grant_r%0d mask %b got id %0d pulses %0d exp id %0d", r, m, g, p, e); else n_pass++;
      end
      n_total++; if (bus.scores_out !== exp_packed()) $display("FAIL rnd_scores_r%0d got %h exp %h", r, bus.scores_out, exp_packed()); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start_in = 1'b0;
    bus.req_n_in = '1;
    model_reset();
    test_reset();
    test_single_grant();
    test_simultaneous();
    test_foul();
    test_saturation();
    test_reset_mid_round();
    test_start_blocked();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired after %0d checks", n_total);
    $fatal(1, "timeout");
  end
endmodule
